regression_window_ctrl: RTL and testbench
=========================================

# regression_window_ctrl

Sequencer for the n·MSE regression datapath. It takes a stream of (x, y) samples and accumulates the window statistics n, Σx, Σy, Σxy, Σx², Σy². It then holds those sums, with β0/β1 latched at window start, stable on the datapath inputs for a fixed settling time, captures n_times_mse and flags the window as an outlier against a threshold. It sits between the sample source and the combinational n·MSE block in the outlier-detection pipeline.

## Interface
Parameters:
- WINDOW, 16, maximum samples per window; legal range 1..256, which keeps Σx and Σy within 16 bits.
- MSE_LAT, 2, cycles the datapath inputs are held stable before the result is captured; minimum 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new window; honoured only in IDLE.
- flush  in  1  end the window early; honoured only in ACCUM with n ≥ 1, or with a same-cycle handshake.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_x  in  8  sample x, unsigned.
- s_y  in  8  sample y, unsigned.
- beta0  in  32  intercept, Q16.16 two's complement; latched on start.
- beta1  in  32  slope, Q16.16 two's complement; latched on start.
- threshold  in  32  outlier threshold, unsigned; latched on start.
- dp_n  out  16  sample count to the datapath.
- dp_sig_x  out  16  Σx to the datapath.
- dp_sig_y  out  16  Σy to the datapath.
- dp_sig_xy  out  32  Σxy to the datapath.
- dp_sig_x2  out  32  Σx² to the datapath.
- dp_sig_y2  out  32  Σy² to the datapath.
- dp_beta0  out  32  latched β0.
- dp_beta1  out  32  latched β1.
- dp_result  in  32  n_times_mse from the datapath.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results valid.
- n_times_mse  out  32  captured result; held until the next done.
- outlier  out  1  n_times_mse > threshold, unsigned compare; held with the result.

## Operation
- States: IDLE, ACCUM, WAIT, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - When start=1: clear all accumulators and the count, latch beta0, beta1 and threshold, then go to ACCUM.
- ACCUM:
  - s_ready=1.
  - Each handshake (s_valid & s_ready) updates, at that edge:
    - n += 1
    - Σx += x and Σy += y, both zero-extended
    - Σxy += x·y, Σx² += x², Σy² += y², each 16-bit product zero-extended to 32 bits
  - Go to WAIT when the handshake makes n = WINDOW, or when flush=1 and the post-update n ≥ 1.
  - A handshake and flush in the same cycle: the sample is included, then go to WAIT.
  - flush with n=0 and no handshake is ignored.
- WAIT:
  - s_ready=0; the dp_* outputs are frozen.
  - A counter runs MSE_LAT cycles.
  - On the last WAIT cycle, capture dp_result into n_times_mse and set outlier; go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start in DONE is ignored; start is accepted in the following IDLE cycle.
- start in ACCUM or WAIT is ignored, with no restart.
- dp_* outputs are driven directly from the accumulator and latch registers at all times; they are never combinationally dependent on s_x/s_y.
- No overflow detection is required; the legal WINDOW range guarantees none occurs.

## Timing
- Reset values:
  - state IDLE.
  - s_ready, busy, done, outlier all 0.
  - n_times_mse 0; all dp_* 0; accumulators and WAIT counter 0.
- rst asserted mid-window, in any state, forces the reset values on the next edge and discards the window.
- start sampled in cycle t gives busy=1 and s_ready=1 in cycle t+1.
- The window-closing handshake in cycle t gives:
  - WAIT in cycles t+1 … t+MSE_LAT
  - capture at the end of cycle t+MSE_LAT
  - done=1 in cycle t+MSE_LAT+1, with n_times_mse and outlier already valid
  - IDLE in cycle t+MSE_LAT+2
- Minimum window turnaround is 1 + WINDOW + MSE_LAT + 1 cycles, plus one IDLE cycle.
- s_ready depends only on state; s_valid may be held high across the ACCUM→WAIT boundary without a sample being consumed.

## Test plan
- **Perfect fit.** Bench uses the real n·MSE datapath. Stimulus: start with β0=0, β1=0x00010000; samples (1,1),(2,2),(3,3),(4,4); WINDOW=4, MSE_LAT=2. Required: dp_sig_x=10, dp_sig_xy=30, dp_sig_x2=30; done 3 cycles after the 4th handshake; n_times_mse=0; outlier=0.
- **Constant y, zero model.** Stimulus: β0=β1=0, threshold=0x000FFFFF; 4 samples of (5,2). Required: dp_sig_y2=16; n_times_mse=0x00100000; outlier=1. Rerun with threshold=0x00100000: outlier=0.
- **Early flush with simultaneous handshake.** Stimulus: 2 samples, then a 3rd handshake with flush=1 in the same cycle. Required: dp_n=3; WAIT entered; exactly one done pulse. Flush asserted with n=0: stays in ACCUM, no done.
- **Backpressure and gaps.** Stimulus: s_valid toggled randomly over a WINDOW=16 window, and s_valid held high through WAIT/DONE. Required: exactly 16 samples accumulated; no samples consumed outside ACCUM; sums match a reference model.
- **Start ignored while busy.** Stimulus: start pulsed in ACCUM and in WAIT. Required: the window is unchanged and the latched β values are not updated.
- **Reset mid-window.** Stimulus: rst for one cycle after 3 handshakes. Required: every output at its reset value on the next cycle, busy=0, dp_n=0; a following start/window completes normally.

Source files
------------

// File: rtl/regression_window_ctrl.sv
// regression_window_ctrl
// Collects a window of (x, y) samples into the sums used by the n*MSE
// regression datapath. Once the window closes, it holds those sums stable
// for MSE_LAT cycles. It then captures the datapath result and flags the
// window as an outlier against a threshold that was latched at window start.
module regression_window_ctrl #(
    parameter int WINDOW  = 16,
    parameter int MSE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_x,
    input  logic [7:0]  s_y,
    input  logic [31:0] beta0,
    input  logic [31:0] beta1,
    input  logic [31:0] threshold,
    output logic [15:0] dp_n,
    output logic [15:0] dp_sig_x,
    output logic [15:0] dp_sig_y,
    output logic [31:0] dp_sig_xy,
    output logic [31:0] dp_sig_x2,
    output logic [31:0] dp_sig_y2,
    output logic [31:0] dp_beta0,
    output logic [31:0] dp_beta1,
    input  logic [31:0] dp_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] n_times_mse,
    output logic        outlier
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The settle counter counts 0 .. MSE_LAT-1, so it needs at least one bit.
    localparam int               CNT_W    = (MSE_LAT > 1) ? $clog2(MSE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSE_LAT - 1);
    localparam logic [15:0]      N_LAST   = 16'(WINDOW);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_waitCnt;
    logic [15:0]      r_n;
    logic [15:0]      r_sigX;
    logic [15:0]      r_sigY;
    logic [31:0]      r_sigXy;
    logic [31:0]      r_sigX2;
    logic [31:0]      r_sigY2;
    logic [31:0]      r_beta0;
    logic [31:0]      r_beta1;
    logic [31:0]      r_threshold;
    logic [31:0]      r_nTimesMse;
    logic             r_outlier;

    logic             w_handshake;
    logic [15:0]      w_nNext;
    logic             w_closeWindow;
    logic             w_lastWait;
    logic [15:0]      w_prodXy;
    logic [15:0]      w_prodX2;
    logic [15:0]      w_prodY2;

    // s_ready comes from state alone, so a handshake is possible only in ACCUM.
    assign w_handshake = s_valid && (r_state == S_ACCUM);
    assign w_nNext     = r_n + 16'd1;

    // The window closes when this sample fills it. It also closes on flush if
    // at least one sample will have been counted after this edge. A flush
    // with an empty window is ignored.
    assign w_closeWindow = (w_handshake && (w_nNext == N_LAST))
                         || (flush && (w_handshake || (r_n != 16'd0)));

    assign w_lastWait = (r_waitCnt == CNT_LAST);

    // The operands are zero-extended, so each 8x8 product fits in 16 bits.
    assign w_prodXy = {8'd0, s_x} * {8'd0, s_y};
    assign w_prodX2 = {8'd0, s_x} * {8'd0, s_x};
    assign w_prodY2 = {8'd0, s_y} * {8'd0, s_y};

    // Sequences IDLE -> ACCUM -> WAIT -> DONE and runs the settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_closeWindow) begin
                        r_state   <= S_WAIT;
                        r_waitCnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_lastWait) begin
                        r_state <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Clears the sums and latches the coefficients on start. Each accepted
    // sample is then added in. Outside ACCUM the sums stay frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= '0;
            r_sigX      <= '0;
            r_sigY      <= '0;
            r_sigXy     <= '0;
            r_sigX2     <= '0;
            r_sigY2     <= '0;
            r_beta0     <= '0;
            r_beta1     <= '0;
            r_threshold <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_n         <= '0;
            r_sigX      <= '0;
            r_sigY      <= '0;
            r_sigXy     <= '0;
            r_sigX2     <= '0;
            r_sigY2     <= '0;
            r_beta0     <= beta0;
            r_beta1     <= beta1;
            r_threshold <= threshold;
        end else if (w_handshake) begin
            r_n     <= w_nNext;
            r_sigX  <= r_sigX + {8'd0, s_x};
            r_sigY  <= r_sigY + {8'd0, s_y};
            r_sigXy <= r_sigXy + {16'd0, w_prodXy};
            r_sigX2 <= r_sigX2 + {16'd0, w_prodX2};
            r_sigY2 <= r_sigY2 + {16'd0, w_prodY2};
        end
    end

    // On the last settle cycle, captures the datapath result and its
    // unsigned threshold compare. Both are then held until the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nTimesMse <= '0;
            r_outlier   <= 1'b0;
        end else if ((r_state == S_WAIT) && w_lastWait) begin
            r_nTimesMse <= dp_result;
            r_outlier   <= (dp_result > r_threshold);
        end
    end

    assign s_ready     = (r_state == S_ACCUM);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign n_times_mse = r_nTimesMse;
    assign outlier     = r_outlier;

    assign dp_n      = r_n;
    assign dp_sig_x  = r_sigX;
    assign dp_sig_y  = r_sigY;
    assign dp_sig_xy = r_sigXy;
    assign dp_sig_x2 = r_sigX2;
    assign dp_sig_y2 = r_sigY2;
    assign dp_beta0  = r_beta0;
    assign dp_beta1  = r_beta1;

endmodule

// File: tb/tb_regression_window_ctrl.sv
// tb_regression_window_ctrl
// Runs directed window vectors against a WINDOW=4 / MSE_LAT=2 instance.
// Also runs a randomized backpressure window against a WINDOW=16 /
// MSE_LAT=3 instance. A behavioural n*MSE model drives dp_result from
// the dp_* outputs.
module tb_regression_window_ctrl;

    localparam int LAT_A = 2;
    localparam int LAT_B = 3;

    typedef struct {
        int          nS;
        logic        fl;
        logic [31:0] xs;
        logic [31:0] ys;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] thr;
        logic [15:0] eN;
        logic [15:0] eSx;
        logic [15:0] eSy;
        logic [31:0] eSxy;
        logic [31:0] eSx2;
        logic [31:0] eSy2;
        logic [31:0] eNmse;
        logic        eOut;
    } vec_t;

    vec_t vecs[8];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic        flush = 1'b0;
    logic        sValid = 1'b0;
    logic [7:0]  sX = '0;
    logic [7:0]  sY = '0;
    logic [31:0] beta0 = '0;
    logic [31:0] beta1 = '0;
    logic [31:0] threshold = '0;

    logic        sReadyA, busyA, doneA, outlierA;
    logic [15:0] dpNA, dpSigXA, dpSigYA;
    logic [31:0] dpSigXyA, dpSigX2A, dpSigY2A, dpBeta0A, dpBeta1A, dpResultA, nTimesMseA;

    logic        sReadyB, busyB, doneB, outlierB;
    logic [15:0] dpNB, dpSigXB, dpSigYB;
    logic [31:0] dpSigXyB, dpSigX2B, dpSigY2B, dpBeta0B, dpBeta1B, dpResultB, nTimesMseB;

    int compared = 0;
    int mismatched = 0;

    // Reference n*MSE = sum((y - b0 - b1*x)^2), expanded over the window sums.
    // All Q16.16 terms are carried at Q32.32 and the Q16.16 result is returned.
    function automatic logic [31:0] nmseModel(input logic [15:0] n, input logic [15:0] sx,
                                              input logic [15:0] sy, input logic [31:0] sxy,
                                              input logic [31:0] sx2, input logic [31:0] sy2,
                                              input logic [31:0] b0, input logic [31:0] b1);
        logic [127:0] wN, wSx, wSy, wSxy, wSx2, wSy2, wB0, wB1, acc;
        wN   = {112'd0, n};
        wSx  = {112'd0, sx};
        wSy  = {112'd0, sy};
        wSxy = {96'd0, sxy};
        wSx2 = {96'd0, sx2};
        wSy2 = {96'd0, sy2};
        wB0  = {{96{b0[31]}}, b0};
        wB1  = {{96{b1[31]}}, b1};
        acc  = (wSy2 << 32)
             - ((128'd2 * wB0 * wSy) << 16)
             - ((128'd2 * wB1 * wSxy) << 16)
             + wN * wB0 * wB0
             + 128'd2 * wB0 * wB1 * wSx
             + wB1 * wB1 * wSx2;
        return acc[47:16];
    endfunction

    assign dpResultA = nmseModel(dpNA, dpSigXA, dpSigYA, dpSigXyA, dpSigX2A, dpSigY2A, dpBeta0A, dpBeta1A);
    assign dpResultB = nmseModel(dpNB, dpSigXB, dpSigYB, dpSigXyB, dpSigX2B, dpSigY2B, dpBeta0B, dpBeta1B);

    regression_window_ctrl #(.WINDOW(4), .MSE_LAT(LAT_A)) dutA (
        .clk(clk), .rst(rst), .start(startA), .flush(flush),
        .s_valid(sValid), .s_ready(sReadyA), .s_x(sX), .s_y(sY),
        .beta0(beta0), .beta1(beta1), .threshold(threshold),
        .dp_n(dpNA), .dp_sig_x(dpSigXA), .dp_sig_y(dpSigYA),
        .dp_sig_xy(dpSigXyA), .dp_sig_x2(dpSigX2A), .dp_sig_y2(dpSigY2A),
        .dp_beta0(dpBeta0A), .dp_beta1(dpBeta1A), .dp_result(dpResultA),
        .busy(busyA), .done(doneA), .n_times_mse(nTimesMseA), .outlier(outlierA)
    );

    regression_window_ctrl #(.WINDOW(16), .MSE_LAT(LAT_B)) dutB (
        .clk(clk), .rst(rst), .start(startB), .flush(flush),
        .s_valid(sValid), .s_ready(sReadyB), .s_x(sX), .s_y(sY),
        .beta0(beta0), .beta1(beta1), .threshold(threshold),
        .dp_n(dpNB), .dp_sig_x(dpSigXB), .dp_sig_y(dpSigYB),
        .dp_sig_xy(dpSigXyB), .dp_sig_x2(dpSigX2B), .dp_sig_y2(dpSigY2B),
        .dp_beta0(dpBeta0B), .dp_beta1(dpBeta1B), .dp_result(dpResultB),
        .busy(busyB), .done(doneB), .n_times_mse(nTimesMseB), .outlier(outlierB)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Stops the run if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no summary, required finish within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, " s_ready"}, 64'(sReadyA), 64'd0);
        checkOutput({tag, " busy"}, 64'(busyA), 64'd0);
        checkOutput({tag, " done"}, 64'(doneA), 64'd0);
        checkOutput({tag, " outlier"}, 64'(outlierA), 64'd0);
        checkOutput({tag, " n_times_mse"}, 64'(nTimesMseA), 64'd0);
        checkOutput({tag, " dp_n"}, 64'(dpNA), 64'd0);
        checkOutput({tag, " dp_sig_x"}, 64'(dpSigXA), 64'd0);
        checkOutput({tag, " dp_sig_y"}, 64'(dpSigYA), 64'd0);
        checkOutput({tag, " dp_sig_xy"}, 64'(dpSigXyA), 64'd0);
        checkOutput({tag, " dp_sig_x2"}, 64'(dpSigX2A), 64'd0);
        checkOutput({tag, " dp_sig_y2"}, 64'(dpSigY2A), 64'd0);
        checkOutput({tag, " dp_beta0"}, 64'(dpBeta0A), 64'd0);
        checkOutput({tag, " dp_beta1"}, 64'(dpBeta1A), 64'd0);
    endtask

    // Runs one table window on dutA. This checks start latency, the frozen
    // sums during WAIT, the exact done cycle, the captured result and the
    // return to IDLE. Odd vectors leave a one-cycle gap before sample 1.
    // preFlush asserts flush on the empty window first; that flush must be ignored.
    task automatic applyStimulus(input int idx, input bit preFlush);
        vec_t  v;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        startA = 1'b1; beta0 = v.b0; beta1 = v.b1; threshold = v.thr;
        @(negedge clk);
        startA = 1'b0;
        checkOutput({tag, " start busy"}, 64'(busyA), 64'd1);
        checkOutput({tag, " start s_ready"}, 64'(sReadyA), 64'd1);
        if (preFlush) begin
            for (int c = 0; c < 3; c++) begin
                flush = 1'b1; sValid = 1'b0;
                @(negedge clk);
                checkOutput({tag, " emptyflush s_ready"}, 64'(sReadyA), 64'd1);
                checkOutput({tag, " emptyflush done"}, 64'(doneA), 64'd0);
                checkOutput({tag, " emptyflush dp_n"}, 64'(dpNA), 64'd0);
            end
            flush = 1'b0;
        end
        for (int k = 0; k < v.nS; k++) begin
            if (k == 1 && (idx % 2) == 1) begin
                sValid = 1'b0;
                @(negedge clk);
            end
            sValid = 1'b1;
            sX     = v.xs[8*k +: 8];
            sY     = v.ys[8*k +: 8];
            flush  = v.fl && (k == v.nS - 1);
            @(negedge clk);
        end
        sValid = 1'b0; flush = 1'b0;
        checkOutput({tag, " dp_n"}, 64'(dpNA), 64'(v.eN));
        checkOutput({tag, " dp_sig_x"}, 64'(dpSigXA), 64'(v.eSx));
        checkOutput({tag, " dp_sig_y"}, 64'(dpSigYA), 64'(v.eSy));
        checkOutput({tag, " dp_sig_xy"}, 64'(dpSigXyA), 64'(v.eSxy));
        checkOutput({tag, " dp_sig_x2"}, 64'(dpSigX2A), 64'(v.eSx2));
        checkOutput({tag, " dp_sig_y2"}, 64'(dpSigY2A), 64'(v.eSy2));
        checkOutput({tag, " dp_beta0"}, 64'(dpBeta0A), 64'(v.b0));
        checkOutput({tag, " dp_beta1"}, 64'(dpBeta1A), 64'(v.b1));
        for (int c = 1; c <= LAT_A; c++) begin
            checkOutput($sformatf("%s wait%0d busy", tag, c), 64'(busyA), 64'd1);
            checkOutput($sformatf("%s wait%0d s_ready", tag, c), 64'(sReadyA), 64'd0);
            checkOutput($sformatf("%s wait%0d done", tag, c), 64'(doneA), 64'd0);
            @(negedge clk);
        end
        checkOutput({tag, " done"}, 64'(doneA), 64'd1);
        checkOutput({tag, " n_times_mse"}, 64'(nTimesMseA), 64'(v.eNmse));
        checkOutput({tag, " outlier"}, 64'(outlierA), 64'(v.eOut));
        @(negedge clk);
        checkOutput({tag, " after done"}, 64'(doneA), 64'd0);
        checkOutput({tag, " after busy"}, 64'(busyA), 64'd0);
        checkOutput({tag, " held result"}, 64'(nTimesMseA), 64'(v.eNmse));
    endtask

    // Main sequence.
    initial begin
        logic [15:0] mN, mSx, mSy;
        logic [31:0] mSxy, mSx2, mSy2, mNmse;
        int          hs;
        int          cyc;

        //        nS fl  xs            ys            b0            b1            thr           eN    eSx       eSy       eSxy        eSx2        eSy2        eNmse         eOut
        vecs[0] = '{4, 1'b0, 32'h04030201, 32'h04030201, 32'h00000000, 32'h00010000, 32'h00000000, 16'd4, 16'd10,   16'd10,   32'd30,     32'd30,     32'd30,     32'h00000000, 1'b0};
        vecs[1] = '{4, 1'b0, 32'h05050505, 32'h02020202, 32'h00000000, 32'h00000000, 32'h000FFFFF, 16'd4, 16'd20,   16'd8,    32'd40,     32'd100,    32'd16,     32'h00100000, 1'b1};
        vecs[2] = '{4, 1'b0, 32'h05050505, 32'h02020202, 32'h00000000, 32'h00000000, 32'h00100000, 16'd4, 16'd20,   16'd8,    32'd40,     32'd100,    32'd16,     32'h00100000, 1'b0};
        vecs[3] = '{3, 1'b1, 32'h00030201, 32'h00040503, 32'h00010000, 32'h00010000, 32'h00040000, 16'd3, 16'd6,    16'd12,   32'd25,     32'd14,     32'd50,     32'h00050000, 1'b1};
        vecs[4] = '{4, 1'b0, 32'h04030201, 32'h03050607, 32'h00080000, 32'hFFFF0000, 32'h00000000, 16'd4, 16'd10,   16'd21,   32'd46,     32'd30,     32'd119,    32'h00010000, 1'b1};
        vecs[5] = '{4, 1'b0, 32'hFF070809, 32'h00000000, 32'h00008000, 32'h00000000, 32'h0000FFFF, 16'd4, 16'd279,  16'd0,    32'd0,      32'd65219,  32'd0,      32'h00010000, 1'b1};
        vecs[6] = '{4, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 16'd4, 16'd1020, 16'd1020, 32'd260100, 32'd260100, 32'd260100, 32'hF8040000, 1'b1};
        vecs[7] = '{1, 1'b1, 32'h000000C8, 32'h00000064, 32'h00000000, 32'h00000000, 32'h27100000, 16'd1, 16'd200,  16'd100,  32'd20000,  32'd40000,  32'd10000,  32'h27100000, 1'b0};

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetA("reset");
        checkOutput("reset busyB", 64'(busyB), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, 1'b0);
        end

        // Flush with an empty window is ignored; the window then completes normally.
        applyStimulus(0, 1'b1);

        // start pulses in ACCUM and WAIT must not restart or relatch.
        @(negedge clk);
        startA = 1'b1; beta0 = 32'h00010000; beta1 = 32'h00020000; threshold = 32'h00000000;
        @(negedge clk);
        startA = 1'b0;
        sValid = 1'b1; sX = 8'd1; sY = 8'd1;
        @(negedge clk);
        sValid = 1'b0;
        startA = 1'b1; beta0 = 32'h11111111; beta1 = 32'h22222222; threshold = 32'hFFFFFFFF;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("busystart accum dp_beta0", 64'(dpBeta0A), 64'h00010000);
        checkOutput("busystart accum dp_beta1", 64'(dpBeta1A), 64'h00020000);
        checkOutput("busystart accum dp_n", 64'(dpNA), 64'd1);
        checkOutput("busystart accum s_ready", 64'(sReadyA), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            sValid = 1'b1; sX = 8'(k); sY = 8'(k);
            @(negedge clk);
        end
        sValid = 1'b0;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("busystart wait dp_beta0", 64'(dpBeta0A), 64'h00010000);
        checkOutput("busystart wait dp_n", 64'(dpNA), 64'd4);
        checkOutput("busystart wait s_ready", 64'(sReadyA), 64'd0);
        checkOutput("busystart wait done", 64'(doneA), 64'd0);
        @(negedge clk);
        checkOutput("busystart done", 64'(doneA), 64'd1);
        checkOutput("busystart n_times_mse", 64'(nTimesMseA), 64'h00360000);
        checkOutput("busystart outlier", 64'(outlierA), 64'd1);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("donestart busy", 64'(busyA), 64'd0);
        checkOutput("donestart done", 64'(doneA), 64'd0);
        @(negedge clk);
        checkOutput("donestart idle", 64'(busyA), 64'd0);

        // Reset after three handshakes discards the window.
        startA = 1'b1; beta0 = 32'h00001234; beta1 = 32'h00005678; threshold = 32'd5;
        @(negedge clk);
        startA = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sValid = 1'b1; sX = 8'(k + 3); sY = 8'(k + 1);
            @(negedge clk);
        end
        sValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetA("midreset");
        applyStimulus(4, 1'b0);

        // Randomized s_valid over a 16-sample window, then s_valid held through WAIT/DONE.
        mN = '0; mSx = '0; mSy = '0; mSxy = '0; mSx2 = '0; mSy2 = '0;
        @(negedge clk);
        startB = 1'b1; beta0 = 32'h0; beta1 = 32'h0; threshold = 32'h0;
        @(negedge clk);
        startB = 1'b0;
        hs  = 0;
        cyc = 0;
        while (hs < 16 && cyc < 400) begin
            sValid = 1'($urandom_range(0, 1));
            sX     = 8'($urandom_range(0, 255));
            sY     = 8'($urandom_range(0, 255));
            checkOutput("bp s_ready", 64'(sReadyB), 64'd1);
            if (sValid) begin
                mN   = mN + 16'd1;
                mSx  = mSx + {8'd0, sX};
                mSy  = mSy + {8'd0, sY};
                mSxy = mSxy + 32'(sX) * 32'(sY);
                mSx2 = mSx2 + 32'(sX) * 32'(sX);
                mSy2 = mSy2 + 32'(sY) * 32'(sY);
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("bp handshakes within budget", 64'(hs), 64'd16);
        for (int c = 1; c <= LAT_B + 3; c++) begin
            sValid = 1'b1;
            sX     = 8'($urandom_range(0, 255));
            sY     = 8'($urandom_range(0, 255));
            checkOutput($sformatf("bp hold%0d s_ready", c), 64'(sReadyB), 64'd0);
            checkOutput($sformatf("bp hold%0d done", c), 64'(doneB), 64'(c == LAT_B + 1));
            checkOutput($sformatf("bp hold%0d busy", c), 64'(busyB), 64'(c <= LAT_B + 1));
            checkOutput($sformatf("bp hold%0d dp_n", c), 64'(dpNB), 64'(mN));
            @(negedge clk);
        end
        sValid = 1'b0;
        mNmse = nmseModel(mN, mSx, mSy, mSxy, mSx2, mSy2, 32'h0, 32'h0);
        checkOutput("bp dp_sig_x", 64'(dpSigXB), 64'(mSx));
        checkOutput("bp dp_sig_y", 64'(dpSigYB), 64'(mSy));
        checkOutput("bp dp_sig_xy", 64'(dpSigXyB), 64'(mSxy));
        checkOutput("bp dp_sig_x2", 64'(dpSigX2B), 64'(mSx2));
        checkOutput("bp dp_sig_y2", 64'(dpSigY2B), 64'(mSy2));
        checkOutput("bp n_times_mse", 64'(nTimesMseB), 64'(mNmse));
        checkOutput("bp outlier", 64'(outlierB), 64'(mNmse != 32'h0));
        checkOutput("bp dutA untouched", 64'(busyA), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
